// File: rtl/wb_b3_sram_if.sv
// Wishbone B3 bus bundle between the external bus master and the SRAM controller.
// Signal suffixes are from the slave's point of view.
interface wb_b3_sram_if #(
  parameter int AW = 32
);
  logic [AW-1:0] wb_adr_i;
  logic [31:0]   wb_dat_i;
  logic [3:0]    wb_sel_i;
  logic          wb_we_i;
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic [2:0]    wb_cti_i;
  logic [1:0]    wb_bte_i;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o;
  logic          wb_err_o;
  logic          wb_rty_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/wb_b3_sram_ctrl.sv
// Wishbone B3 slave in front of a synchronous single-port SRAM (1-cycle read latency).
// Classic cycles ack after one wait cycle; B3 bursts stream one beat per clock.
module wb_b3_sram_ctrl #(
  parameter int unsigned MEM_SIZE = 134217728,
  parameter int          AW       = 32,
  parameter int          SRAM_AW  = $clog2(MEM_SIZE / 4)
) (
  input  logic               clk,
  input  logic               rst_n,
  wb_b3_sram_if.slave        wb,
  output logic               sram_ce_o,
  output logic               sram_we_o,
  output logic [3:0]         sram_be_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [31:0]        sram_wdata_o,
  input  logic [31:0]        sram_rdata_i
);

  // One spare bit so a linear increment past the last word is still seen as out of range.
  typedef logic [AW-2:0] waddr_t;
  localparam waddr_t MEM_WORDS = waddr_t'(MEM_SIZE / 4);

  typedef enum logic [1:0] {S_IDLE, S_CLASSIC, S_BURST, S_ERR} state_t;

  state_t state_q, state_d;
  waddr_t baddr_q, baddr_d;

  logic   req;
  logic   is_burst;
  logic   last_beat;
  logic   start_oor;
  logic   nxt_oor;
  logic   ack;
  logic   err;
  waddr_t start_w;
  waddr_t inc_w;
  waddr_t wrap_mask;
  waddr_t nxt_w;
  waddr_t sram_w;
  logic   unused_bits;

  // Gating with rst_n keeps the SRAM and bus quiet while reset is held.
  assign req       = wb.wb_cyc_i & wb.wb_stb_i & rst_n;
  assign is_burst  = (wb.wb_cti_i == 3'b001) || (wb.wb_cti_i == 3'b010);
  assign last_beat = (wb.wb_cti_i == 3'b111);
  assign start_w   = {1'b0, wb.wb_adr_i[AW-1:2]};
  assign start_oor = (start_w >= MEM_WORDS);
  assign inc_w     = baddr_q + waddr_t'(1);

  always_comb begin
    wrap_mask = waddr_t'(0);
    case (wb.wb_bte_i)
      2'b01:   wrap_mask = waddr_t'(3);
      2'b10:   wrap_mask = waddr_t'(7);
      2'b11:   wrap_mask = waddr_t'(15);
      default: wrap_mask = waddr_t'(0);
    endcase
  end

  always_comb begin
    nxt_w = inc_w;
    if (wb.wb_cti_i == 3'b001) begin
      nxt_w = baddr_q;
    end else if (wb.wb_bte_i != 2'b00) begin
      nxt_w = (baddr_q & ~wrap_mask) | (inc_w & wrap_mask);
    end
  end

  assign nxt_oor = (nxt_w >= MEM_WORDS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baddr_q <= '0;
    end else begin
      state_q <= state_d;
      baddr_q <= baddr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    baddr_d   = baddr_q;
    ack       = 1'b0;
    err       = 1'b0;
    sram_ce_o = 1'b0;
    sram_we_o = 1'b0;
    sram_be_o = 4'hF;
    sram_w    = baddr_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          baddr_d = start_w;
          sram_w  = start_w;
          if (start_oor) begin
            state_d = S_ERR;
          end else begin
            // Reads are issued now so data is ready on the first ack cycle.
            sram_ce_o = !wb.wb_we_i;
            state_d   = is_burst ? S_BURST : S_CLASSIC;
          end
        end
      end
      S_CLASSIC: begin
        ack       = 1'b1;
        sram_ce_o = wb.wb_we_i;
        sram_we_o = wb.wb_we_i;
        sram_be_o = wb.wb_we_i ? wb.wb_sel_i : 4'hF;
        state_d   = S_IDLE;
      end
      S_ERR: begin
        err     = 1'b1;
        state_d = S_IDLE;
      end
      S_BURST: begin
        if (!wb.wb_cyc_i) begin
          state_d = S_IDLE;
        end else begin
          ack = req;
          if (req && wb.wb_we_i) begin
            sram_ce_o = 1'b1;
            sram_we_o = 1'b1;
            sram_be_o = wb.wb_sel_i;
          end else begin
            // Prefetch the next beat on ack; on a wait state re-read the current one.
            sram_w    = req ? nxt_w : baddr_q;
            sram_ce_o = !(req && nxt_oor);
          end
          if (req) begin
            baddr_d = nxt_w;
            if (last_beat) begin
              state_d = S_IDLE;
            end else if (nxt_oor) begin
              state_d = S_ERR;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sram_addr_o  = sram_w[SRAM_AW-1:0];
  assign sram_wdata_o = wb.wb_dat_i;

  assign wb.wb_ack_o = ack;
  assign wb.wb_err_o = err;
  assign wb.wb_rty_o = 1'b0;
  assign wb.wb_dat_o = ack ? sram_rdata_i : 32'h0;

  assign unused_bits = ^{wb.wb_adr_i[1:0], sram_w[AW-2:SRAM_AW]};

endmodule

// File: tb/tb_wb_b3_sram_ctrl.sv
// Randomized bench for wb_b3_sram_ctrl: a word-array reference of memory contents and
// burst address arithmetic predicts every ack, err and read beat.
module tb_wb_b3_sram_ctrl;

  localparam int unsigned MEM_SIZE = 2048;
  localparam int          WORDS    = MEM_SIZE / 4;
  localparam int          SRAM_AW  = $clog2(WORDS);

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               sram_ce;
  logic               sram_we;
  logic [3:0]         sram_be;
  logic [SRAM_AW-1:0] sram_addr;
  logic [31:0]        sram_wdata;
  logic [31:0]        sram_rdata;
  logic               fill_en;

  logic [31:0] sram_mem [0:WORDS-1];
  logic [31:0] ref_mem  [0:WORDS-1];

  int n_tests = 0;
  int n_fail  = 0;

  wb_b3_sram_if #(.AW(32)) bus ();

  wb_b3_sram_ctrl #(
    .MEM_SIZE(MEM_SIZE),
    .AW      (32),
    .SRAM_AW (SRAM_AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb          (bus.slave),
    .sram_ce_o   (sram_ce),
    .sram_we_o   (sram_we),
    .sram_be_o   (sram_be),
    .sram_addr_o (sram_addr),
    .sram_wdata_o(sram_wdata),
    .sram_rdata_i(sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fill_word(input int i);
    return (32'(i) * 32'h9E3779B9) ^ 32'hA5A50000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  // Next burst word: constant, linear, or wrap inside an aligned block of 4/8/16 words.
  function automatic int next_word(input int a, input logic [2:0] cti, input logic [1:0] bte);
    int len;
    if (cti == 3'b001) return a;
    if (bte == 2'b00) return a + 1;
    len = 2 << bte;
    return (a / len) * len + ((a % len) + 1) % len;
  endfunction

  // Synchronous SRAM macro model with one-cycle read latency.
  always @(posedge clk) begin
    if (fill_en) begin
      for (int i = 0; i < WORDS; i++) sram_mem[i] <= fill_word(i);
    end else if (sram_ce) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++) begin
          if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    chk(tag, {31'b0, got}, {31'b0, exp});
  endtask

  task automatic bus_idle();
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = 32'h0;
    bus.wb_dat_i = 32'h0;
    bus.wb_sel_i = 4'h0;
    bus.wb_cti_i = 3'b000;
    bus.wb_bte_i = 2'b00;
  endtask

  task automatic classic(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rd);
    int w;
    bit oor;
    w   = int'(adr >> 2);
    oor = (adr >> 2) >= 32'(WORDS);
    @(negedge clk);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_adr_i = adr;
    bus.wb_dat_i = dat;
    bus.wb_sel_i = sel;
    bus.wb_cti_i = 3'b000;
    bus.wb_bte_i = 2'b00;
    #1;
    chk1("c_idle_ack", bus.wb_ack_o, 1'b0);
    chk1("c_idle_ce", sram_ce, !we && !oor);
    @(negedge clk);
    #1;
    chk1("c_ack", bus.wb_ack_o, !oor);
    chk1("c_err", bus.wb_err_o, oor);
    rd = bus.wb_dat_o;
    if (oor) begin
      chk1("c_err_ce", sram_ce, 1'b0);
    end else if (we) begin
      chk1("c_we", sram_we, 1'b1);
      ref_mem[w] = merge(ref_mem[w], dat, sel);
    end else begin
      chk("c_rdata", rd, ref_mem[w]);
    end
    @(negedge clk);
    bus_idle();
    #1;
    chk1("c_done", bus.wb_ack_o | bus.wb_err_o, 1'b0);
    $display("[TB] classic %s adr=%h sel=%h oor=%0d data=%h", we ? "wr" : "rd", adr, sel, oor,
             we ? dat : rd);
  endtask

  task automatic burst(input bit we, input int start, input int n, input logic [2:0] cti,
                       input logic [1:0] bte, input int wait_beat, input int wait_len,
                       input int wait_pct, input int rst_beat);
    int a;
    int nw;
    int beats;
    bit oor;
    a     = start;
    beats = 0;
    @(negedge clk);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_adr_i = 32'(a) << 2;
    bus.wb_dat_i = $urandom;
    bus.wb_sel_i = 4'($urandom_range(1, 15));
    bus.wb_cti_i = (n == 1) ? 3'b111 : cti;
    bus.wb_bte_i = bte;
    #1;
    chk1("b_idle_ack", bus.wb_ack_o, 1'b0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      oor = (a >= WORDS);
      nw  = (i == wait_beat) ? wait_len : 0;
      if (i > 0 && !oor && wait_pct > 0 && $urandom_range(99) < 32'(wait_pct))
        nw = nw + int'($urandom_range(1, 2));
      for (int k = 0; k < nw; k++) begin
        bus.wb_stb_i = 1'b0;
        #1;
        chk1("b_wait_ack", bus.wb_ack_o, 1'b0);
        @(negedge clk);
      end
      bus.wb_stb_i = 1'b1;
      if (i > 0) begin
        bus.wb_adr_i = 32'(a) << 2;
        bus.wb_dat_i = $urandom;
        bus.wb_sel_i = 4'($urandom_range(1, 15));
        bus.wb_cti_i = (i == n - 1) ? 3'b111 : cti;
      end
      #1;
      if (i == rst_beat) begin
        chk1("rst_pre_ack", bus.wb_ack_o, 1'b1);
        chk1("rst_pre_we", sram_we, we);
        rst_n = 1'b0;
        #1;
        chk1("rst_ack", bus.wb_ack_o, 1'b0);
        chk1("rst_err", bus.wb_err_o, 1'b0);
        chk1("rst_ce", sram_ce, 1'b0);
        chk1("rst_we", sram_we, 1'b0);
        chk("rst_dat", bus.wb_dat_o, 32'h0);
        break;
      end
      chk1("b_ack", bus.wb_ack_o, !oor);
      chk1("b_err", bus.wb_err_o, oor);
      if (oor) break;
      if (we) ref_mem[a] = merge(ref_mem[a], bus.wb_dat_i, bus.wb_sel_i);
      else chk("b_rdata", bus.wb_dat_o, ref_mem[a]);
      beats++;
      a = next_word(a, cti, bte);
    end
    @(negedge clk);
    bus_idle();
    #1;
    chk1("b_done", bus.wb_ack_o | bus.wb_err_o, 1'b0);
    if (rst_beat >= 0) begin
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
    end
    $display("[TB] burst %s start=%h n=%0d cti=%b bte=%b beats_done=%0d", we ? "wr" : "rd",
             start, n, cti, bte, beats);
  endtask

  task automatic mem_compare(input string tag);
    int ndiff;
    ndiff = 0;
    for (int i = 0; i < WORDS; i++) begin
      if (sram_mem[i] !== ref_mem[i]) ndiff++;
    end
    chk(tag, 32'(ndiff), 32'h0);
    $display("[TB] memory image %s: %0d differing words", tag, ndiff);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    bit          we;
    int          kind;
    int          st;
    int          n;
    logic [2:0]  cti;
    logic [1:0]  bte;

    bus_idle();
    fill_en = 1'b1;
    rst_n   = 1'b0;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = fill_word(i);

    // Request held during reset must not reach the bus or SRAM.
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_adr_i = 32'h100;
    repeat (3) @(negedge clk);
    #1;
    chk1("reset_ack", bus.wb_ack_o, 1'b0);
    chk1("reset_err", bus.wb_err_o, 1'b0);
    chk1("reset_rty", bus.wb_rty_o, 1'b0);
    chk1("reset_ce", sram_ce, 1'b0);
    chk1("reset_we", sram_we, 1'b0);
    chk("reset_dat", bus.wb_dat_o, 32'h0);
    $display("[TB] reset outputs sampled");
    bus_idle();
    fill_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    classic(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, rd);
    classic(1'b0, 32'h100, 32'h0, 4'hF, rd);
    chk("t1_read", rd, 32'hDEADBEEF);

    classic(1'b1, 32'h100, 32'h0000AB00, 4'b0010, rd);
    classic(1'b0, 32'h100, 32'h0, 4'hF, rd);
    chk("t2_byte", rd, 32'hDEADABEF);

    burst(1'b0, 32'h108 >> 2, 4, 3'b010, 2'b01, -1, 0, 0, -1);
    burst(1'b1, 32'h80, 8, 3'b010, 2'b00, 4, 2, 0, -1);
    mem_compare("t4_image");

    classic(1'b0, MEM_SIZE - 4, 32'h0, 4'hF, rd);
    classic(1'b0, MEM_SIZE, 32'h0, 4'hF, rd);

    burst(1'b1, 32'h20, 16, 3'b010, 2'b11, -1, 0, 0, 2);
    mem_compare("t6_image");
    classic(1'b0, 32'h100, 32'h0, 4'hF, rd);
    chk("t6_after_rst", rd, 32'hDEADABEF);

    burst(1'b0, WORDS - 3, 6, 3'b010, 2'b00, -1, 0, 0, -1);
    burst(1'b1, 32'h30, 3, 3'b001, 2'b00, -1, 0, 0, -1);
    burst(1'b0, 32'h55, 9, 3'b010, 2'b10, -1, 0, 30, -1);

    for (int t = 0; t < 60; t++) begin
      we   = 1'($urandom_range(1));
      kind = int'($urandom_range(3));
      if (kind == 0) begin
        classic(we, 32'($urandom_range(0, WORDS + 7)) << 2, $urandom,
                4'($urandom_range(1, 15)), rd);
      end else begin
        n   = int'($urandom_range(2, 16));
        cti = (kind == 1) ? 3'b001 : 3'b010;
        bte = 2'($urandom_range(3));
        if (kind == 3) begin
          bte = 2'b00;
          st  = WORDS - int'($urandom_range(1, 10));
        end else begin
          st  = int'($urandom_range(0, WORDS - 1));
        end
        burst(we, st, n, cti, bte, -1, 0, 30, -1);
      end
    end
    mem_compare("final_image");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
